// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit arbiter: line-code enums, the per-requester
// frame configuration record, the arbiter FSM states and the reset configuration.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    BAUD_CODE_0 = 2'b00,
    BAUD_CODE_1 = 2'b01,
    BAUD_CODE_2 = 2'b10,
    BAUD_CODE_3 = 2'b11
  } baud_e;

  // Code 2'b11 is interpreted by uart_tx_top itself.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_ODD  = 2'b01,
    PARITY_EVEN = 2'b10,
    PARITY_ALT  = 2'b11
  } parity_e;

  // Bit order matches {tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length}.
  typedef struct packed {
    logic [1:0] baud;
    logic [1:0] parity;
    logic       stop;
    logic       len;
  } cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_BUSY   = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  // 8-bit frames, no parity, one stop bit, slowest baud code.
  localparam cfg_t CFG_DEFAULT = '{baud: 2'b00, parity: 2'b00, stop: 1'b0, len: 1'b1};

  function automatic cfg_t cfg_pack(input logic [1:0] baud, input logic [1:0] parity,
                                    input logic stop, input logic len);
    cfg_t c;
    c.baud   = baud;
    c.parity = parity;
    c.stop   = stop;
    c.len    = len;
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Connection between the arbiter and uart_tx_top: frame controls one way,
// transmitter status the other.
interface uart_tx_arbiter_if;
  logic       tx_send;
  logic [1:0] tx_baud_rate;
  logic [7:0] tx_data_in;
  logic [1:0] tx_parity_type;
  logic       tx_stop_bits;
  logic       tx_data_length;
  logic       tx_active;
  logic       tx_done;

  modport master (
    output tx_send, tx_baud_rate, tx_data_in, tx_parity_type, tx_stop_bits, tx_data_length,
    input  tx_active, tx_done
  );

  modport slave (
    input  tx_send, tx_baud_rate, tx_data_in, tx_parity_type, tx_stop_bits, tx_data_length,
    output tx_active, tx_done
  );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: the first valid requester at or after the
// pointer, wrapping around to index 0.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    pointer,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic hit_s;

  // Two passes: indices from the pointer upward, then the wrapped indices below it.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    hit_s     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_s     = !any_valid && req_valid[i] && (i >= int'(pointer));
      winner    = hit_s ? ID_W'(i) : winner;
      any_valid = any_valid | hit_s;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_s     = !any_valid && req_valid[i] && (i < int'(pointer));
      winner    = hit_s ? ID_W'(i) : winner;
      any_valid = any_valid | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_top among NUM_REQ byte requesters,
// each with its own frame configuration held in a small config bank.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int LAUNCH_TO = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic                 cfg_we,
  input  logic [ID_W-1:0]      cfg_sel,
  input  logic [1:0]           cfg_baud,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop,
  input  logic                 cfg_len,
  uart_tx_arbiter_if.master    tx,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 frame_done,
  output logic                 launch_err
);

  localparam int                CNT_W    = $clog2(LAUNCH_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TO - 1);

  cfg_t               cfg_bank_r [NUM_REQ];
  state_e             state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    winner_r;
  logic [ID_W-1:0]    grant_id_r;
  logic [NUM_REQ-1:0] req_ready_r;
  logic               tx_send_r;
  logic [7:0]         tx_data_r;
  cfg_t               tx_cfg_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               frame_done_r;
  logic               launch_err_r;

  logic [ID_W-1:0]    winner_s;
  logic               any_valid_s;
  logic [ID_W-1:0]    next_ptr_s;

  uart_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req_valid (req_valid),
    .pointer   (ptr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Pointer moves to the slot just after the requester being granted.
  always_comb begin
    next_ptr_s = '0;
    if (int'(winner_r) == NUM_REQ - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = winner_r + ID_W'(1'b1);
    end
  end

  // Config bank; a frame in flight keeps its own snapshot so writes here never disturb it.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cfg_bank_r[i] <= CFG_DEFAULT;
      end
    end else if (cfg_we && (int'(cfg_sel) < NUM_REQ)) begin
      cfg_bank_r[cfg_sel] <= cfg_pack(cfg_baud, cfg_parity, cfg_stop, cfg_len);
    end else begin
      cfg_bank_r[0] <= cfg_bank_r[0];
    end
  end

  // Arbitration FSM with registered outputs; the snapshot in GRANT reads the bank
  // before any write landing on the same edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      winner_r     <= '0;
      grant_id_r   <= '0;
      req_ready_r  <= '0;
      tx_send_r    <= 1'b0;
      tx_data_r    <= 8'h00;
      tx_cfg_r     <= '0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      launch_err_r <= 1'b0;
    end else begin
      req_ready_r  <= '0;
      frame_done_r <= 1'b0;
      launch_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            winner_r    <= winner_s;
            req_ready_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
            busy_r      <= 1'b1;
            state_r     <= ST_GRANT;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_GRANT: begin
          tx_data_r  <= req_data[{winner_r, 3'b000} +: 8];
          tx_cfg_r   <= cfg_bank_r[winner_r];
          grant_id_r <= winner_r;
          ptr_r      <= next_ptr_s;
          tx_send_r  <= 1'b1;
          cnt_r      <= '0;
          state_r    <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          if (tx.tx_done) begin
            // Frame finished inside the launch window.
            tx_send_r    <= 1'b0;
            frame_done_r <= 1'b1;
            state_r      <= ST_GAP;
          end else if (tx.tx_active) begin
            state_r <= ST_BUSY;
          end else if (cnt_r == CNT_LAST) begin
            // Transmitter never started: drop the byte.
            tx_send_r    <= 1'b0;
            launch_err_r <= 1'b1;
            state_r      <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_BUSY: begin
          if (tx.tx_done) begin
            tx_send_r    <= 1'b0;
            frame_done_r <= 1'b1;
            state_r      <= ST_GAP;
          end else begin
            tx_send_r <= 1'b1;
          end
        end
        ST_GAP: begin
          // One low cycle so the next frame always sees a fresh send edge.
          tx_send_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          tx_send_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready         = req_ready_r;
  assign busy              = busy_r;
  assign grant_id          = grant_id_r;
  assign frame_done        = frame_done_r;
  assign launch_err        = launch_err_r;
  assign tx.tx_send        = tx_send_r;
  assign tx.tx_data_in     = tx_data_r;
  assign tx.tx_baud_rate   = tx_cfg_r.baud;
  assign tx.tx_parity_type = tx_cfg_r.parity;
  assign tx.tx_stop_bits   = tx_cfg_r.stop;
  assign tx.tx_data_length = tx_cfg_r.len;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple behavioural stand-in for uart_tx_top.
module tb_uart_tx_arbiter;
  import uart_tx_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int LAUNCH_TO = 16;

  logic         clock = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [31:0]  req_data;
  logic         cfg_we;
  logic [1:0]   cfg_sel;
  logic [1:0]   cfg_baud;
  logic [1:0]   cfg_parity;
  logic         cfg_stop;
  logic         cfg_len;
  logic         busy;
  logic [1:0]   grant_id;
  logic         frame_done;
  logic         launch_err;

  uart_tx_arbiter_if tx_if();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LAUNCH_TO(LAUNCH_TO)) dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_baud   (cfg_baud),
    .cfg_parity (cfg_parity),
    .cfg_stop   (cfg_stop),
    .cfg_len    (cfg_len),
    .tx         (tx_if),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done),
    .launch_err (launch_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [7:0] data;
    cfg_t       cfg;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  cfg_t cfg_model [NUM_REQ];

  int   total = 0;
  int   bad   = 0;
  int   n_done = 0;
  int   n_err  = 0;
  int   ready_cnt [NUM_REQ];
  logic [3:0] clr_mask = 4'b0;
  logic prev_send = 1'b0;
  int   low_run  = 0;
  int   high_run = 0;
  bit   seen_frame = 1'b0;
  bit   active_en  = 1'b1;
  int   frame_len  = 6;
  int   rsp_phase  = 0;
  int   rsp_timer  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: requester side, monitor/scoreboard, then the transmitter stand-in.
  task automatic tick();
    logic rise;
    @(negedge clock);
    req_valid = req_valid & ~clr_mask;
    clr_mask  = 4'b0;
    if (req_ready != 4'b0) begin
      check_val("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      clr_mask = req_ready;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) ready_cnt[i]++;
    end
    rise = tx_if.tx_send && !prev_send;
    if (rise) begin
      if (seen_frame) check_val("gap_len", 32'(low_run >= 3), 32'd1);
      seen_frame = 1'b1;
      high_run   = 0;
      check_val("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        cur_exp = sb_q.pop_front();
        check_val("grant_id", 32'(grant_id), 32'(cur_exp.id));
        check_val("tx_data", 32'(tx_if.tx_data_in), 32'(cur_exp.data));
        check_val("tx_cfg", 32'({tx_if.tx_baud_rate, tx_if.tx_parity_type,
                                 tx_if.tx_stop_bits, tx_if.tx_data_length}), 32'(cur_exp.cfg));
      end
      if (active_en) begin
        rsp_phase = 1;
        rsp_timer = 2;
      end
    end
    if (tx_if.tx_send) begin
      high_run++;
      low_run = 0;
    end else begin
      low_run++;
    end
    if (frame_done) begin
      n_done++;
      check_val("done_id", 32'(grant_id), 32'(cur_exp.id));
      check_val("done_data", 32'(tx_if.tx_data_in), 32'(cur_exp.data));
      check_val("done_cfg", 32'({tx_if.tx_baud_rate, tx_if.tx_parity_type,
                                 tx_if.tx_stop_bits, tx_if.tx_data_length}), 32'(cur_exp.cfg));
    end
    if (launch_err) begin
      n_err++;
      check_val("launch_len", 32'(high_run), 32'(LAUNCH_TO));
    end
    prev_send = tx_if.tx_send;
    case (rsp_phase)
      1: if (rsp_timer == 0) begin
           tx_if.tx_active = 1'b1; rsp_phase = 2; rsp_timer = frame_len;
         end else rsp_timer--;
      2: if (rsp_timer == 0) begin
           tx_if.tx_done = 1'b1; rsp_phase = 3;
         end else rsp_timer--;
      3: begin
           tx_if.tx_done = 1'b0; tx_if.tx_active = 1'b0; rsp_phase = 0;
         end
      default: ;
    endcase
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_REQ; i++) cfg_model[i] = CFG_DEFAULT;
    sb_q.delete();
    seen_frame = 1'b0;
    clr_mask   = 4'b0;
    rsp_phase  = 0;
    tx_if.tx_active = 1'b0;
    tx_if.tx_done   = 1'b0;
    req_valid  = 4'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic request(input int id, input logic [7:0] d);
    exp_t e;
    req_data[id*8 +: 8] = d;
    req_valid[id] = 1'b1;
    e.id = id; e.data = d; e.cfg = cfg_model[id];
    sb_q.push_back(e);
  endtask

  task automatic cfg_write(input int id, input logic [1:0] b, input logic [1:0] p,
                           input logic s, input logic l);
    cfg_we = 1'b1; cfg_sel = 2'(id);
    cfg_baud = b; cfg_parity = p; cfg_stop = s; cfg_len = l;
    tick();
    cfg_we = 1'b0;
    cfg_model[id] = cfg_pack(b, p, s, l);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (n_done < target && n < 3000) begin tick(); n++; end
    check_val(tag, 32'(n_done), 32'(target));
  endtask

  task automatic wait_err(input int target, input string tag);
    int n = 0;
    while (n_err < target && n < 3000) begin tick(); n++; end
    check_val(tag, 32'(n_err), 32'(target));
  endtask

  task automatic wait_active(input string tag);
    int n = 0;
    while (!tx_if.tx_active && n < 200) begin tick(); n++; end
    check_val(tag, 32'(tx_if.tx_active), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; req_data = 32'h0; cfg_we = 1'b0; cfg_sel = 2'b00;
    cfg_baud = 2'b00; cfg_parity = 2'b00; cfg_stop = 1'b0; cfg_len = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
    reset_model();
    tick(); tick(); tick();
    check_val("rst_send", 32'(tx_if.tx_send), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_gid", 32'(grant_id), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_len", 32'(tx_if.tx_data_length), 32'd0);
    rst = 1'b0;
    tick();

    // Single request with custom config on requester 0.
    cfg_write(0, 2'b00, 2'b01, 1'b1, 1'b1);
    request(0, 8'hCC);
    wait_done(1, "s1_done");
    check_val("s1_ready_cnt", 32'(ready_cnt[0]), 32'd1);

    // Requesters 0, 1, 3 at once from reset, then 0 again.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
    base = n_done;
    request(0, 8'hA0); request(1, 8'hA1); request(3, 8'hA3);
    n = 0;
    while (ready_cnt[0] < 1 && n < 500) begin tick(); n++; end
    check_val("s2_first_grant", 32'(ready_cnt[0]), 32'd1);
    tick();
    request(0, 8'hB0);
    wait_done(base + 4, "s2_done");
    check_val("s2_ready0", 32'(ready_cnt[0]), 32'd2);
    check_val("s2_ready2", 32'(ready_cnt[2]), 32'd0);

    // Per-requester configuration.
    cfg_write(2, 2'b11, 2'b11, 1'b1, 1'b0);
    cfg_write(1, 2'b01, 2'b10, 1'b0, 1'b1);
    base = n_done;
    request(2, 8'h27); wait_done(base + 1, "s3_a");
    request(1, 8'h91); wait_done(base + 2, "s3_b");
    request(2, 8'h3C); wait_done(base + 3, "s3_c");

    // Config write while requester 2's frame is in flight.
    base = n_done;
    request(2, 8'h5A);
    wait_active("s4_active");
    cfg_write(2, 2'b00, 2'b01, 1'b0, 1'b1);
    wait_done(base + 1, "s4_old");
    request(2, 8'hA5);
    wait_done(base + 2, "s4_new");

    // Transmitter never goes active: both frames time out, served 3 then 1.
    active_en = 1'b0;
    base = n_done;
    request(3, 8'h33); request(1, 8'h11);
    wait_err(2, "s5_err");
    check_val("s5_no_done", 32'(n_done), 32'(base));
    active_en = 1'b1;

    // Reset in the middle of a long frame.
    frame_len = 40;
    base = n_done;
    request(1, 8'h77);
    wait_active("s6_active");
    tick(); tick();
    rst = 1'b1;
    reset_model();
    tick();
    check_val("s6_send", 32'(tx_if.tx_send), 32'd0);
    check_val("s6_busy", 32'(busy), 32'd0);
    check_val("s6_gid", 32'(grant_id), 32'd0);
    check_val("s6_no_done", 32'(n_done), 32'(base));
    rst = 1'b0;
    frame_len = 6;
    tick();
    request(2, 8'h42);
    wait_done(base + 1, "s6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx_top between NUM_REQ byte requesters. Each requester has its own frame configuration: baud_rate, parity_type, stop_bits and data_length.
Grants requesters in round-robin order. For each granted frame it snapshots the data and configuration, drives send, and waits for tx_done.
Sits directly in front of uart_tx_top. Its tx_* outputs connect one-to-one to the transmitter's inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester index
LAUNCH_TO, 16, cycles allowed for tx_active to rise after send asserts

Ports:
clock  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester byte pending
req_ready  out  NUM_REQ  one-hot grant/accept pulse
req_data  in  8*NUM_REQ  requester i data in bits [8i+7:8i]
cfg_we  in  1  config write strobe
cfg_sel  in  ID_W  requester whose config is written
cfg_baud  in  2  baud_rate code
cfg_parity  in  2  parity_type code
cfg_stop  in  1  stop_bits
cfg_len  in  1  data_length (1 = 8-bit, 0 = 7-bit)
tx_send  out  1  to uart_tx_top send
tx_baud_rate  out  2  to uart_tx_top
tx_data_in  out  8  to uart_tx_top
tx_parity_type  out  2  to uart_tx_top
tx_stop_bits  out  1  to uart_tx_top
tx_data_length  out  1  to uart_tx_top
tx_active  in  1  from uart_tx_top
tx_done  in  1  from uart_tx_top
busy  out  1  state != IDLE
grant_id  out  ID_W  requester of current/last frame
frame_done  out  1  1-cycle pulse on successful frame completion
launch_err  out  1  1-cycle pulse on launch timeout

Behaviour:
- Reset values:
  - Outputs: all outputs 0; round-robin pointer 0.
  - Config bank: every entry baud=00, parity=00, stop=0, len=1.
  - State: IDLE.
- Reset mid-frame: tx_send drops at the next edge. No frame_done is issued. Any partially sent frame is abandoned.
- Config bank:
  - A cfg_we write takes effect at the clock edge.
  - Writes never disturb a frame already launched; the snapshot is held.
  - A write to a requester in the same cycle as its grant: the snapshot takes the pre-write value.
- FSM states: IDLE, GRANT, LAUNCH, BUSY, GAP.
- IDLE:
  - If any req_valid is set, pick the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - Register the winner and go to GRANT.
- GRANT (1 cycle):
  - req_ready[winner]=1.
  - Capture req_data slice and the winner's config into the tx_* registers.
  - Set grant_id=winner, pointer=winner+1 (wrapping), tx_send=1, clear launch counter; go to LAUNCH.
  - The requester must hold req_valid and data stable until req_ready.
- LAUNCH:
  - If tx_active=1, go to BUSY.
  - Else increment the counter. When the counter reaches LAUNCH_TO-1: tx_send=0, pulse launch_err, go to GAP. The byte is dropped.
- BUSY:
  - tx_send stays 1. tx_* configuration is held stable for the whole frame.
  - On tx_done=1: tx_send=0, pulse frame_done, go to GAP.
- GAP (1 cycle): tx_send=0, guaranteeing a send edge for the next frame; go to IDLE.
- Throughput: minimum 3 overhead cycles (IDLE, GRANT, GAP) between frames.
- tx_done while in LAUNCH counts as completion, i.e. a frame shorter than the observation window.
- tx_done in any other state is ignored.
- req_valid dropping after grant has no effect on the frame in flight.

Decomposition:
- Package uart_tx_pkg holds:
  - baud_rate codes (00..11) and parity_type codes (00 none, 01 odd, 10 even, 11 as defined by uart_tx_top);
  - cfg struct {baud, parity, stop, len};
  - FSM state enum;
  - reset-default cfg constant.
- One sub-module: uart_rr_picker. Combinational round-robin select: inputs req_valid and pointer; outputs winner index and any_valid.

Test Plan:
- Single request: cfg[0]=baud 00/parity 01/stop 1/len 1, req_valid[0] with data 0xCC.
  -> req_ready[0] pulses once; tx_data_in=0xCC; tx_send=1 until tx_done; frame_done=1 with grant_id=0.
- Requesters 0, 1 and 3 valid simultaneously from reset.
  -> Grant order 0, 1, 3; then 0 again if still valid. Each frame separated by a tx_send=0 GAP cycle.
- Per-requester config: cfg[2]=baud 11/parity 11/stop 1/len 0, cfg[1]=baud 01/parity 10/len 1. Alternate requests.
  -> tx_* pins match the granted requester for the whole frame.
- cfg_we to requester 2 while its frame is in BUSY.
  -> tx_* unchanged until tx_done; the next frame from requester 2 uses the new value.
- tx_active tied 0.
  -> After 16 LAUNCH cycles: tx_send=0, launch_err pulse, no frame_done; the next requester is served.
- rst asserted mid-BUSY.
  -> Next edge: tx_send=0, busy=0, grant_id=0, config bank at defaults; a later request is granted normally.
